// File: rtl/i2c_slave.sv
// Byte-oriented I2C target: START/STOP decode, 7-bit address match, byte shifting,
// and SCL stretching at every byte boundary until local logic strobes ws.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0] ADDR  = 7'h50,
    parameter int         NSYNC = 2
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        sda,
    inout  wire        scl,
    input  logic [7:0] dat,
    input  logic       ws,
    output logic [7:0] dat_out,
    output logic [3:0] stat_out
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_ADDR = 4'd1, S_AACK = 4'd2, S_WRX  = 4'd3, S_WSTR = 4'd4,
        S_WACK = 4'd5, S_TSTR = 4'd6, S_TX   = 4'd7, S_TACK = 4'd8, S_IGN  = 4'd9
    } state_e;

    state_e           state_q, state_d;
    logic [NSYNC-1:0] scl_sync_q, sda_sync_q;
    logic             scl_hist_q, sda_hist_q;
    logic [2:0]       cnt_q, cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       dat_out_q, dat_out_d;
    logic             bdone_q, bdone_d;
    logic             sda_oe_q, sda_oe_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sel_q, sel_d, rd_q, rd_d, rdy_q, rdy_d, ack_q, ack_d;

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, ws_acc;
    logic [7:0] rx_byte;

    assign scl_s    = scl_sync_q[NSYNC-1];
    assign sda_s    = sda_sync_q[NSYNC-1];
    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;
    // SCL must be high on both samples so our own SDA change at a stretch release is not a START/STOP.
    assign start_det = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
    assign stop_det  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;
    assign ws_acc    = ws & rdy_q;
    assign rx_byte   = {shreg_q[6:0], sda_s};

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign scl      = scl_oe_q ? 1'b0 : 1'bz;
    assign dat_out  = dat_out_q;
    assign stat_out = {ack_q, rdy_q, rd_q, sel_q};

    // Line synchronizers, edge history and all state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= {NSYNC{1'b1}};
            sda_sync_q <= {NSYNC{1'b1}};
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 3'd7;
            shreg_q    <= 8'h00;
            dat_out_q  <= 8'h00;
            bdone_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            sel_q      <= 1'b0;
            rd_q       <= 1'b0;
            rdy_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[NSYNC-2:0], scl};
            sda_sync_q <= {sda_sync_q[NSYNC-2:0], sda};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            dat_out_q  <= dat_out_d;
            bdone_q    <= bdone_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            rdy_q      <= rdy_d;
            ack_q      <= ack_d;
        end
    end

    // Next-state logic; START/STOP override every state.
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = S_IDLE;
        end else if (start_det) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && cnt_q == 3'd0) state_d = (rx_byte[7:1] == ADDR) ? S_AACK : S_IGN;
                    else state_d = state_q;
                end
                S_AACK: begin
                    if (scl_fall && sda_oe_q) state_d = rd_q ? S_TSTR : S_WRX;
                    else state_d = state_q;
                end
                S_WRX: begin
                    if (scl_fall && bdone_q) state_d = S_WSTR;
                    else state_d = state_q;
                end
                S_WSTR: begin
                    if (ws_acc) state_d = S_WACK;
                    else state_d = state_q;
                end
                S_WACK: begin
                    if (scl_fall) state_d = S_WRX;
                    else state_d = state_q;
                end
                S_TSTR: begin
                    if (ws_acc) state_d = S_TX;
                    else state_d = state_q;
                end
                S_TX: begin
                    if (scl_fall && bdone_q) state_d = S_TACK;
                    else state_d = state_q;
                end
                S_TACK: begin
                    if (scl_fall) state_d = ack_q ? S_TSTR : S_IGN;
                    else state_d = state_q;
                end
                S_IDLE, S_IGN: state_d = state_q;
                default:       state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and line-drive next values; line drives only change after a detected SCL fall or an accepted ws.
    always_comb begin
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        dat_out_d = dat_out_q;
        bdone_d   = bdone_q;
        sda_oe_d  = sda_oe_q;
        scl_oe_d  = scl_oe_q;
        sel_d     = sel_q;
        rd_d      = rd_q;
        rdy_d     = rdy_q;
        ack_d     = ack_q;
        if (stop_det) begin
            cnt_d = 3'd7; bdone_d = 1'b0; sda_oe_d = 1'b0; scl_oe_d = 1'b0;
            sel_d = 1'b0; rd_d = 1'b0; rdy_d = 1'b0;
        end else if (start_det) begin
            cnt_d = 3'd7; bdone_d = 1'b0; sda_oe_d = 1'b0; scl_oe_d = 1'b0;
            sel_d = 1'b0; rdy_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shreg_d = rx_byte;
                        if (cnt_q == 3'd0) begin
                            cnt_d = 3'd7;
                            if (rx_byte[7:1] == ADDR) begin
                                sel_d = 1'b1;
                                rd_d  = rx_byte[0];
                            end else begin
                                sel_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_AACK: begin
                    // First fall starts the ACK drive, the second (9th clock) ends it.
                    if (scl_fall) begin
                        if (sda_oe_q) begin
                            sda_oe_d = 1'b0;
                            if (rd_q) begin
                                scl_oe_d = 1'b1;
                                rdy_d    = 1'b1;
                            end else begin
                                scl_oe_d = scl_oe_q;
                            end
                        end else begin
                            sda_oe_d = 1'b1;
                        end
                    end else begin
                        sda_oe_d = sda_oe_q;
                    end
                end
                S_WRX: begin
                    if (scl_rise) begin
                        shreg_d = rx_byte;
                        if (cnt_q == 3'd0) begin
                            cnt_d   = 3'd7;
                            bdone_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (scl_fall && bdone_q) begin
                        bdone_d   = 1'b0;
                        scl_oe_d  = 1'b1;
                        rdy_d     = 1'b1;
                        dat_out_d = shreg_q;
                    end else begin
                        bdone_d = bdone_q;
                    end
                end
                S_WSTR: begin
                    if (ws_acc) begin
                        rdy_d    = 1'b0;
                        scl_oe_d = 1'b0;
                        sda_oe_d = ~dat[0];
                    end else begin
                        rdy_d = rdy_q;
                    end
                end
                S_WACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    else sda_oe_d = sda_oe_q;
                end
                S_TSTR: begin
                    if (ws_acc) begin
                        shreg_d  = dat;
                        rdy_d    = 1'b0;
                        sda_oe_d = ~dat[7];
                        scl_oe_d = 1'b0;
                        cnt_d    = 3'd7;
                        bdone_d  = 1'b0;
                    end else begin
                        rdy_d = rdy_q;
                    end
                end
                S_TX: begin
                    if (scl_rise) begin
                        if (cnt_q == 3'd0) begin
                            cnt_d   = 3'd7;
                            bdone_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (scl_fall) begin
                        if (bdone_q) begin
                            bdone_d  = 1'b0;
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d = ~shreg_q[6];
                            shreg_d  = {shreg_q[6:0], 1'b0};
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_TACK: begin
                    if (scl_rise) begin
                        ack_d = ~sda_s;
                    end else if (scl_fall && ack_q) begin
                        scl_oe_d = 1'b1;
                        rdy_d    = 1'b1;
                    end else begin
                        ack_d = ack_q;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master, ws responder, and an RDY-event scoreboard.
`timescale 1ns/1ps
module tb_i2c_slave;
    localparam int HALF  = 20;
    localparam int BOUND = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dat = 8'h00;
    logic       ws  = 1'b0;
    logic [7:0] dat_out;
    logic [3:0] stat_out;
    logic       tb_sda_low = 1'b0;
    logic       tb_scl_low = 1'b0;
    wire        sda, scl;

    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    assign scl = tb_scl_low ? 1'b0 : 1'bz;
    pullup (sda);
    pullup (scl);

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(7'h50), .NSYNC(2)) dut (
        .clk(clk), .rst(rst), .sda(sda), .scl(scl), .dat(dat), .ws(ws),
        .dat_out(dat_out), .stat_out(stat_out)
    );

    int          total = 0;
    int          bad   = 0;
    int          stretch_viol = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  hdat_q[$];
    int          hdel_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_up();
        int n;
        tb_scl_low = 1'b0;
        n = 0;
        while (scl !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) begin
            total++;
            bad++;
            $display("FAIL scl_release: scl still low after %0d cycles, expected release", n);
        end
    endtask

    task automatic send_bit(input logic b);
        tb_sda_low = ~b;
        wait_clk(HALF);
        scl_up();
        wait_clk(HALF);
        tb_scl_low = 1'b1;
        wait_clk(2);
    endtask

    task automatic read_bit(output logic b);
        tb_sda_low = 1'b0;
        wait_clk(HALF);
        scl_up();
        wait_clk(HALF / 2);
        b = sda;
        wait_clk(HALF / 2);
        tb_scl_low = 1'b1;
        wait_clk(2);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ackb);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        read_bit(ackb);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            b[i] = bt;
        end
        send_bit(mack);
    endtask

    task automatic i2c_start();
        tb_sda_low = 1'b0;
        wait_clk(HALF);
        scl_up();
        wait_clk(HALF);
        tb_sda_low = 1'b1;
        wait_clk(HALF);
        tb_scl_low = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic i2c_stop();
        tb_sda_low = 1'b1;
        wait_clk(HALF);
        scl_up();
        wait_clk(HALF);
        tb_sda_low = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic expect_rdy(input logic [3:0] st, input logic [7:0] d, input int delay, input logic [7:0] hd);
        exp_q.push_back({st, d});
        hdel_q.push_back(delay);
        hdat_q.push_back(hd);
    endtask

    // Scoreboard monitor: every rising RDY must match the next queued {stat_out, dat_out}.
    initial begin
        logic        rdy_prev;
        logic [11:0] e;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (stat_out[2] && !rdy_prev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rdy_event: got stat=%0h dat_out=%0h expected no RDY", stat_out, dat_out);
                end else begin
                    e = exp_q.pop_front();
                    check("rdy_event", {20'h0, stat_out, dat_out}, {20'h0, e});
                end
            end
            rdy_prev = stat_out[2];
        end
    end

    // Host responder: waits the queued delay (SCL must stay low), then strobes ws with the queued byte.
    initial begin
        int         d;
        logic [7:0] hd;
        forever begin
            @(negedge clk);
            if (stat_out[2] && hdel_q.size() > 0) begin
                d  = hdel_q.pop_front();
                hd = hdat_q.pop_front();
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (scl !== 1'b0) stretch_viol++;
                end
                dat = hd;
                ws  = 1'b1;
                @(negedge clk);
                ws  = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic       ab;
        logic [7:0] rb;
        logic       b0, b1, b2;

        rst = 1'b0;
        wait_clk(5);
        check("reset_stat", stat_out, 4'h0);
        check("reset_dat_out", dat_out, 8'h00);
        check("reset_sda", sda, 1'b1);
        check("reset_scl", scl, 1'b1);
        rst = 1'b1;
        wait_clk(5);

        dat = 8'hFF; ws = 1'b1;
        wait_clk(1);
        ws = 1'b0;
        wait_clk(3);
        check("stray_ws", stat_out, 4'h0);

        // Write 0xA0, 0x3C, STOP.
        i2c_start();
        write_byte(8'hA0, ab);
        check("t1_addr_ack", ab, 1'b0);
        check("t1_sel", stat_out, 4'b0001);
        expect_rdy(4'b0101, 8'h3C, 5, 8'h00);
        write_byte(8'h3C, ab);
        check("t1_data_ack", ab, 1'b0);
        i2c_stop();
        wait_clk(5);
        check("t1_stat_after_stop", stat_out, 4'h0);
        check("t1_dat_out_kept", dat_out, 8'h3C);

        // Read 0x96 (master ACK) then 0x5A (master NACK).
        i2c_start();
        expect_rdy(4'b0111, 8'h3C, 3, 8'h96);
        write_byte(8'hA1, ab);
        check("t2_addr_ack", ab, 1'b0);
        expect_rdy(4'b1111, 8'h3C, 3, 8'h5A);
        read_byte(1'b0, rb);
        check("t2_byte1", rb, 8'h96);
        read_byte(1'b1, rb);
        check("t2_byte2", rb, 8'h5A);
        wait_clk(5);
        check("t2_ign_stat", stat_out, 4'b0011);
        i2c_stop();
        wait_clk(5);
        check("t2_stat_after_stop", stat_out, 4'h0);

        // Foreign address 0x42.
        i2c_start();
        write_byte(8'h84, ab);
        check("t3_addr_nack", ab, 1'b1);
        write_byte(8'h11, ab);
        check("t3_data_nack", ab, 1'b1);
        check("t3_stat", stat_out, 4'h0);
        check("t3_dat_out", dat_out, 8'h3C);
        i2c_stop();
        wait_clk(5);

        // Host NACKs a written byte after a long delay.
        i2c_start();
        write_byte(8'hA0, ab);
        check("t4_addr_ack", ab, 1'b0);
        expect_rdy(4'b0101, 8'h77, 1000, 8'h01);
        write_byte(8'h77, ab);
        check("t4_data_nack", ab, 1'b1);
        check("t4_stretch_held", stretch_viol, 0);
        i2c_stop();
        wait_clk(5);

        // Write then repeated START into a read.
        i2c_start();
        write_byte(8'hA0, ab);
        check("t5_addr_ack", ab, 1'b0);
        expect_rdy(4'b0101, 8'h3C, 5, 8'h00);
        write_byte(8'h3C, ab);
        check("t5_data_ack", ab, 1'b0);
        i2c_start();
        expect_rdy(4'b0111, 8'h3C, 5, 8'hC3);
        write_byte(8'hA1, ab);
        check("t5_raddr_ack", ab, 1'b0);
        read_byte(1'b1, rb);
        check("t5_read", rb, 8'hC3);
        i2c_stop();
        wait_clk(5);
        check("t5_stat_after_stop", stat_out, 4'h0);

        // Reset while the target drives SDA low mid-byte.
        i2c_start();
        expect_rdy(4'b0111, 8'h3C, 5, 8'h00);
        write_byte(8'hA1, ab);
        check("t6_addr_ack", ab, 1'b0);
        read_bit(b0);
        read_bit(b1);
        read_bit(b2);
        check("t6_bits", {b0, b1, b2}, 3'b000);
        tb_sda_low = 1'b0;
        wait_clk(HALF);
        scl_up();
        wait_clk(4);
        check("t6_sda_driven", sda, 1'b0);
        rst = 1'b0;
        #1;
        check("t6_rst_sda", sda, 1'b1);
        check("t6_rst_scl", scl, 1'b1);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(3);
        check("t6_stat", stat_out, 4'h0);
        check("t6_dat_out", dat_out, 8'h00);

        wait_clk(20);
        check("sb_empty", exp_q.size(), 0);
        check("host_q_empty", hdel_q.size(), 0);
        check("stretch_total", stretch_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
# i2c_slave

Byte-oriented I2C target with a 7-bit address, sitting on the same open-drain SDA/SCL pair as the team's I2C master. It decodes START/STOP, matches its address, and shifts bytes in and out. It holds SCL low (clock stretching) at every byte boundary until local logic services it through a single-strobe handshake, so the host needs no hard real-time response.

## Interface
- ADDR, 7'h50, 7-bit target address.
- NSYNC, 2, synchronizer depth for SCL/SDA (≥2).
- clk  input  1  system clock; frequency ≥ 10× SCL frequency.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- sda  inout  1  open-drain data; driven only as 0 or Z.
- scl  inout  1  open-drain clock; driven only as 0 (stretch) or Z.
- dat  input  8  TX byte on read transfers; bit0 = NACK select on write transfers.
- ws  input  1  one-cycle service strobe; honoured only while stat_out[RDY]=1.
- dat_out  output  8  last received data byte.
- stat_out  output  4  bit0 SEL (addressed), bit1 RD (master reading), bit2 RDY (stretching, service required), bit3 ACK (master ACKed last TX byte).

## Operation
- SCL and SDA pass through NSYNC flops, plus one history flop for edge detection.
  - START: synchronized SDA falls while SCL high.
  - STOP: synchronized SDA rises while SCL high.
- States: IDLE, ADDR, AACK, WRX, WSTR, WACK, TSTR, TX, TACK, IGN.
- START in any state → ADDR, bit counter = 7, SDA released, SCL released, SEL=0. Covers repeated START.
- STOP in any state → IDLE, everything released, SEL=0, RD=0, RDY=0. dat_out and ACK are kept.
- Bits are sampled on the SCL rising edge, MSB first. SDA is changed only on the cycle after an SCL falling edge is detected.
- ADDR, after 8 bits:
  - If byte[7:1]==ADDR: SEL=1, RD=byte[0], go to AACK. On the next SCL fall, drive SDA=0 for the 9th clock.
  - Otherwise go to IGN and stay there until START or STOP. The block never drives in IGN.
- AACK ends on the 9th-clock SCL fall.
  - RD=0 → WRX: release SDA.
  - RD=1 → TSTR: drive SCL=0, RDY=1.
- WRX, after 8 bits: on the following SCL fall drive SCL=0, load dat_out, set RDY=1, go to WSTR.
- WSTR, on ws: RDY=0, release SCL, drive SDA = dat[0] (0 = ACK, 1 = NACK), go to WACK. At the 9th-clock fall release SDA and go to WRX.
- TSTR, on ws: latch dat into the shift register, RDY=0, drive SDA = bit7, release SCL, go to TX.
  - On each SCL fall present the next bit.
  - After the 8th rise, at the next fall release SDA and go to TACK.
- TACK samples SDA on the 9th rise:
  - SDA=0 → ACK=1, and at the fall go to TSTR (stretch again).
  - SDA=1 → ACK=0, go to IGN with SEL kept until STOP or START.
- ws while RDY=0 has no effect. dat is sampled only on an accepted ws.

## Timing
- Reset values:
  - sda = Z, scl = Z.
  - dat_out = 8'h00, stat_out = 4'h0.
  - state = IDLE, counter = 7.
- Line-to-internal latency is NSYNC clk cycles.
- A drive change follows a detected SCL fall by exactly 1 clk, so the total is NSYNC+1 clk after the pin edge.
- A stretch is asserted within NSYNC+1 clk of SCL falling. The master's SCL-high wait absorbs this.
- RDY rises in the same cycle SCL is first driven low.
- SCL is released in the cycle after ws is accepted. The TX bit7 or ACK value is on SDA in that same cycle.
- If a START or STOP coincides with ws in the same cycle, START/STOP wins and ws is dropped.
- If reset asserts mid-transfer, both lines release immediately (asynchronous).
- If STOP arrives during a stretch, the stretch drops and RDY clears. This cannot happen while this block holds SCL low; it is defined for robustness.

## Test plan
- Write 0xA0 (addr 0x50 W), then 0x3C, then STOP; host answers ws with dat=0x00 → ACK on the address, RDY with dat_out=0x3C, ACK on data, SEL=0 after STOP.
- Read 0xA1, host supplies 0x96 then 0x5A, master ACKs then NACKs → SDA bits 1001_0110 then 0101_1010; ACK=1 after byte 1, ACK=0 after byte 2, then IGN until STOP.
- Address 0x42 W with 0x11 → no ACK (SDA Z on the 9th clock), SEL=0, no RDY, dat_out unchanged.
- Write a byte, host answers with dat=0x01 → NACK (SDA Z on the 9th clock); SCL is held low until ws, verified over a 1000-cycle host delay.
- Write 0x3C, then repeated START with 0xA1 → RD=1, RDY=1 for the TX byte, no STOP required in between.
- Assert rst mid-TX while SDA=0 → sda and scl Z in the same cycle; stat_out=0 and dat_out=0x00 after release.
